// File: rtl/bus_port_if.sv
// Per-device bus port: TX FIFO toward the arbiter (pndng/pop/D_pop), RX FIFO with ID/broadcast filter.
// Define BUS_PORT_OVFL_CNT_EN to build the saturating TX overflow / RX drop counters.
module bus_port_if #(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  id        = 8'h00,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tx_wr,
  input  logic [pckg_sz-1:0]           tx_data,
  output logic                         tx_full,
  output logic [$clog2(depth+1)-1:0]   tx_count,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           D_pop,
  input  logic                         pop,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           D_push,
  input  logic                         rx_rd,
  output logic [pckg_sz-1:0]           rx_data,
  output logic                         rx_valid,
  output logic                         rx_full,
  output logic [7:0]                   tx_ovfl_cnt,
  output logic [7:0]                   rx_drop_cnt
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(depth + 1);

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [PW-1:0]      tx_wr_ptr, tx_rd_ptr;
  logic [PW-1:0]      rx_wr_ptr, rx_rd_ptr;

  logic tx_empty, tx_push, tx_pop;
  logic rx_empty, rx_match, rx_push, rx_pop;

  // TX status and handshake; a write into a full FIFO is allowed when the head leaves this cycle
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]) && (tx_wr_ptr[AW] != tx_rd_ptr[AW]);
  assign tx_pop   = pop && !tx_empty;
  assign tx_push  = tx_wr && (!tx_full || pop);
  assign tx_count = CW'(tx_wr_ptr - tx_rd_ptr);
  assign pndng    = !tx_empty;
  assign D_pop    = tx_empty ? '0 : tx_mem[tx_rd_ptr[AW-1:0]];

  // RX filter: accept own ID or broadcast
  assign rx_match = push && ((D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == broadcast));
  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]) && (rx_wr_ptr[AW] != rx_rd_ptr[AW]);
  assign rx_pop   = rx_rd && !rx_empty;
  assign rx_push  = rx_match && (!rx_full || rx_rd);
  assign rx_valid = !rx_empty;
  assign rx_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: the head outputs are masked while empty
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= tx_data;
    if (rx_push) rx_mem[rx_wr_ptr[AW-1:0]] <= D_push;
  end

`ifdef BUS_PORT_OVFL_CNT_EN
  logic       tx_ovfl_evt, rx_drop_evt;
  logic [7:0] tx_ovfl_q, rx_drop_q;

  assign tx_ovfl_evt = tx_wr && tx_full && !pop;
  assign rx_drop_evt = rx_match && rx_full && !rx_rd;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovfl_q <= 8'h00;
      rx_drop_q <= 8'h00;
    end else begin
      if (tx_ovfl_evt && (tx_ovfl_q != 8'hFF)) tx_ovfl_q <= tx_ovfl_q + 8'd1;
      if (rx_drop_evt && (rx_drop_q != 8'hFF)) rx_drop_q <= rx_drop_q + 8'd1;
    end
  end

  assign tx_ovfl_cnt = tx_ovfl_q;
  assign rx_drop_cnt = rx_drop_q;
`else
  assign tx_ovfl_cnt = 8'h00;
  assign rx_drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_bus_port_if.sv
// Directed bench for bus_port_if (id=2, depth=8, 16-bit packets): vector table plus corner sequences.
module tb_bus_port_if;

  logic        clk;
  logic        reset;
  logic        tx_wr;
  logic [15:0] tx_data;
  logic        tx_full;
  logic [3:0]  tx_count;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        rx_rd;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_full;
  logic [7:0]  tx_ovfl_cnt;
  logic [7:0]  rx_drop_cnt;

  int errors = 0;
  int checks = 0;

`ifdef BUS_PORT_OVFL_CNT_EN
  localparam logic [7:0] EXP_EVT = 8'd1;
`else
  localparam logic [7:0] EXP_EVT = 8'd0;
`endif

  bus_port_if #(.pckg_sz(16), .depth(8), .id(8'h02), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
    .tx_ovfl_cnt(tx_ovfl_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        tx_wr;
    logic [15:0] tx_data;
    logic        pop;
    logic        push;
    logic [15:0] d_push;
    logic        rx_rd;
    logic        e_pndng;
    logic [15:0] e_dpop;
    logic [3:0]  e_cnt;
    logic        e_full;
    logic        e_rxv;
    logic [15:0] e_rxd;
    logic        e_rxf;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: inputs held across the edge, outputs settle by #1 after it
  task automatic step(input logic w, input logic [15:0] wd, input logic p,
                      input logic ps, input logic [15:0] dp, input logic rd);
    tx_wr = w; tx_data = wd; pop = p; push = ps; D_push = dp; rx_rd = rd;
    @(posedge clk);
    #1;
    tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
  endtask

  initial begin
    //          name            wr  tx_data  pop psh d_push   rd  pndng d_pop    cnt full rxv rx_data  rxf
    vecs[0]  = '{"wr_0312",     1, 16'h0312, 0, 0, 16'h0000, 0,  1, 16'h0312, 1, 0,  0, 16'h0000, 0};
    vecs[1]  = '{"wr_01ab",     1, 16'h01AB, 0, 0, 16'h0000, 0,  1, 16'h0312, 2, 0,  0, 16'h0000, 0};
    vecs[2]  = '{"pop_1",       0, 16'h0000, 1, 0, 16'h0000, 0,  1, 16'h01AB, 1, 0,  0, 16'h0000, 0};
    vecs[3]  = '{"pop_2",       0, 16'h0000, 1, 0, 16'h0000, 0,  0, 16'h0000, 0, 0,  0, 16'h0000, 0};
    vecs[4]  = '{"pop_empty",   0, 16'h0000, 1, 0, 16'h0000, 0,  0, 16'h0000, 0, 0,  0, 16'h0000, 0};
    vecs[5]  = '{"wrpop_empty", 1, 16'h0077, 1, 0, 16'h0000, 0,  1, 16'h0077, 1, 0,  0, 16'h0000, 0};
    vecs[6]  = '{"wrpop_busy",  1, 16'h0088, 1, 0, 16'h0000, 0,  1, 16'h0088, 1, 0,  0, 16'h0000, 0};
    vecs[7]  = '{"pop_3",       0, 16'h0000, 1, 0, 16'h0000, 0,  0, 16'h0000, 0, 0,  0, 16'h0000, 0};
    vecs[8]  = '{"rx_own",      0, 16'h0000, 0, 1, 16'h02AA, 0,  0, 16'h0000, 0, 0,  1, 16'h02AA, 0};
    vecs[9]  = '{"rx_other",    0, 16'h0000, 0, 1, 16'h05BB, 0,  0, 16'h0000, 0, 0,  1, 16'h02AA, 0};
    vecs[10] = '{"rx_bcast",    0, 16'h0000, 0, 1, 16'hFFCC, 0,  0, 16'h0000, 0, 0,  1, 16'h02AA, 0};
    vecs[11] = '{"rx_rd_1",     0, 16'h0000, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 0,  1, 16'hFFCC, 0};
    vecs[12] = '{"rx_rd_2",     0, 16'h0000, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 0,  0, 16'h0000, 0};
    vecs[13] = '{"rx_rd_empty", 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 0,  0, 16'h0000, 0};

    reset = 1'b0; tx_wr = 1'b0; tx_data = '0; pop = 1'b0; push = 1'b0; D_push = '0; rx_rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    chk("rst_pndng", 32'(pndng), 32'd0);
    chk("rst_dpop", 32'(D_pop), 32'd0);
    chk("rst_cnt", 32'(tx_count), 32'd0);
    chk("rst_txfull", 32'(tx_full), 32'd0);
    chk("rst_rxvalid", 32'(rx_valid), 32'd0);
    chk("rst_rxdata", 32'(rx_data), 32'd0);
    chk("rst_rxfull", 32'(rx_full), 32'd0);
    chk("rst_ovfl", 32'(tx_ovfl_cnt), 32'd0);
    chk("rst_drop", 32'(rx_drop_cnt), 32'd0);

    foreach (vecs[i]) begin
      step(vecs[i].tx_wr, vecs[i].tx_data, vecs[i].pop, vecs[i].push, vecs[i].d_push, vecs[i].rx_rd);
      chk({vecs[i].name, "_pndng"}, 32'(pndng), 32'(vecs[i].e_pndng));
      chk({vecs[i].name, "_dpop"}, 32'(D_pop), 32'(vecs[i].e_dpop));
      chk({vecs[i].name, "_cnt"}, 32'(tx_count), 32'(vecs[i].e_cnt));
      chk({vecs[i].name, "_txfull"}, 32'(tx_full), 32'(vecs[i].e_full));
      chk({vecs[i].name, "_rxvalid"}, 32'(rx_valid), 32'(vecs[i].e_rxv));
      chk({vecs[i].name, "_rxdata"}, 32'(rx_data), 32'(vecs[i].e_rxd));
      chk({vecs[i].name, "_rxfull"}, 32'(rx_full), 32'(vecs[i].e_rxf));
    end
    chk("filter_drop_cnt", 32'(rx_drop_cnt), 32'd0);
    chk("filter_ovfl_cnt", 32'(tx_ovfl_cnt), 32'd0);

    // TX fill, overflow, then write+pop while full
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0, 16'h0000, 1'b0);
      if (i == 7) begin
        chk("txfill_full", 32'(tx_full), 32'd1);
        chk("txfill_cnt", 32'(tx_count), 32'd8);
      end
    end
    chk("txovf_cnt", 32'(tx_count), 32'd8);
    chk("txovf_full", 32'(tx_full), 32'd1);
    chk("txovf_head", 32'(D_pop), 32'h1000);
    chk("txovf_evt", 32'(tx_ovfl_cnt), 32'(EXP_EVT));
    step(1'b1, 16'h1008, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("txfullwp_cnt", 32'(tx_count), 32'd8);
    chk("txfullwp_full", 32'(tx_full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("txdrain_%0d", i), 32'(D_pop), 32'(16'h1000 + i));
      step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    end
    chk("txdrain_pndng", 32'(pndng), 32'd0);
    chk("txdrain_ovfl_hold", 32'(tx_ovfl_cnt), 32'(EXP_EVT));

    // RX fill, drop on full, capture on full with simultaneous read
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b0, 1'b1, 16'(16'h0200 + i), 1'b0);
    chk("rxfill_full", 32'(rx_full), 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0209, 1'b0);
    chk("rxdrop_full", 32'(rx_full), 32'd1);
    chk("rxdrop_head", 32'(rx_data), 32'h0200);
    chk("rxdrop_evt", 32'(rx_drop_cnt), 32'(EXP_EVT));
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h020A, 1'b1);
    chk("rxfullrd_full", 32'(rx_full), 32'd1);
    chk("rxfullrd_head", 32'(rx_data), 32'h0201);
    chk("rxfullrd_evt", 32'(rx_drop_cnt), 32'(EXP_EVT));
    for (int i = 1; i <= 8; i++) begin
      logic [15:0] e;
      e = (i < 8) ? 16'(16'h0200 + i) : 16'h020A;
      chk($sformatf("rxdrain_%0d", i), 32'(rx_data), 32'(e));
      step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    end
    chk("rxdrain_valid", 32'(rx_valid), 32'd0);

    // Pointer wrap: streaming write/pop pairs
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 16'(k), (k > 0), 1'b0, 16'h0000, 1'b0);
      chk($sformatf("wrap_dpop_%0d", k), 32'(D_pop), 32'(k));
      chk($sformatf("wrap_cnt_%0d", k), 32'(tx_count), 32'd1);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("wrap_end_pndng", 32'(pndng), 32'd0);

    // Asynchronous reset mid-cycle with both FIFOs occupied
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0500 + i), 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b1, 16'(16'hFF00 + i), 1'b0);
    chk("pre_arst_cnt", 32'(tx_count), 32'd5);
    chk("pre_arst_rxv", 32'(rx_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_pndng", 32'(pndng), 32'd0);
    chk("arst_rxvalid", 32'(rx_valid), 32'd0);
    chk("arst_cnt", 32'(tx_count), 32'd0);
    chk("arst_dpop", 32'(D_pop), 32'd0);
    chk("arst_rxdata", 32'(rx_data), 32'd0);
    chk("arst_ovfl", 32'(tx_ovfl_cnt), 32'd0);
    chk("arst_drop", 32'(rx_drop_cnt), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'h0355, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("post_arst_pndng", 32'(pndng), 32'd1);
    chk("post_arst_dpop", 32'(D_pop), 32'h0355);
    chk("post_arst_cnt", 32'(tx_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_port_if.md
Name: bus_port_if

Overview:
- Per-device port adapter on one driver slot of the bus generator/arbiter. One instance per device.
- TX side: buffers device packets in a FIFO and presents them to the arbiter through the pndng/pop/D_pop handshake.
- RX side: captures arbiter push/D_push deliveries addressed to this port, or to broadcast, into a second FIFO that the device drains.

Parameters:
- pckg_sz, 16, packet width in bits; the destination ID occupies the top 8 bits D[pckg_sz-1:pckg_sz-8].
- depth, 8, entries per FIFO (TX and RX); power of two, minimum 2.
- id, 0, this port's 8-bit destination ID.
- broadcast, 8'hFF, destination ID accepted by every port.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- tx_wr  in  1  device write strobe for TX FIFO.
- tx_data  in  pckg_sz  device packet to send.
- tx_full  out  1  TX FIFO full.
- tx_count  out  $clog2(depth+1)  TX occupancy.
- pndng  out  1  to arbiter: TX FIFO non-empty.
- D_pop  out  pckg_sz  to arbiter: TX head entry, first-word fall-through.
- pop  in  1  from arbiter: consume TX head.
- push  in  1  from arbiter: delivery strobe.
- D_push  in  pckg_sz  from arbiter: delivered packet.
- rx_rd  in  1  device read strobe for RX FIFO.
- rx_data  out  pckg_sz  RX head entry, first-word fall-through.
- rx_valid  out  1  RX FIFO non-empty.
- rx_full  out  1  RX FIFO full.
- tx_ovfl_cnt  out  8  TX overflow counter (optional feature).
- rx_drop_cnt  out  8  RX drop counter (optional feature).

Behaviour:
- Reset values:
  - Both FIFOs empty; pointers 0.
  - tx_full=0, tx_count=0, pndng=0, rx_valid=0, rx_full=0.
  - D_pop=0 and rx_data=0 (head outputs are forced to 0 while the FIFO is empty).
  - Counters=0.
- Reset asserted mid-operation discards all buffered packets. The first edge after reset deassertion behaves as from empty.
- TX write: accepted on an edge with tx_wr=1 if not full, or if full and pop=1 in the same cycle.
- TX overflow: tx_wr=1 while full and pop=0 drops the write; no state change except the overflow event.
- TX pop: pop=1 with pndng=1 advances the read pointer at the edge; the next entry appears on D_pop in the following cycle.
- Pop while empty: ignored, no pointer movement.
- Simultaneous write and pop while empty: write accepted, pop ignored. pndng rises the next cycle.
- Simultaneous write and pop while non-empty: count unchanged; both pointers advance.
- pndng = !tx_empty, registered-state derived. Latency from tx_wr edge to pndng=1 is 1 cycle.
- RX capture: on an edge with push=1, D_push is captured only if D_push[pckg_sz-1 -: 8] equals id or broadcast.
- RX filter miss: non-matching packets are silently ignored and do not count as drops.
- RX full: a matching packet arriving while RX is full with rx_rd=0 is dropped.
- RX full with rx_rd=1 in the same cycle: the read frees a slot and the packet is captured.
- rx_rd while empty: ignored.
- Pointers: $clog2(depth) bits plus 1 wrap bit.
  - full = addresses equal and wrap bits differ.
  - empty = pointers fully equal.
  - Wrap-around is seamless.
- tx_count = wr_ptr - rd_ptr, modulo 2^(log2 depth + 1).
- No combinational path from pop to pndng, or from push to rx_valid.

Optional Feature:
- Macro: BUS_PORT_OVFL_CNT_EN.
- Defined:
  - tx_ovfl_cnt increments on every dropped TX write.
  - rx_drop_cnt increments on every dropped matching RX packet.
  - Both counters are 8-bit, saturate at 255, and are cleared only by reset.
- Undefined: both ports are tied to 8'h00 and no counter flops are synthesized.

Test Plan:
- Basic path: after reset, write 16'h0312, 16'h01AB → pndng=1 one cycle later, D_pop=16'h0312. Pop → D_pop=16'h01AB. Pop → pndng=0, D_pop=0.
- TX full and overflow: write 9 packets, no pops, depth=8 → tx_full=1 after the 8th, tx_count=8, 9th dropped, tx_ovfl_cnt=1 (macro on) / 0 (off). Write+pop while full → accepted, tx_count stays 8, order preserved.
- RX filter: id=2; push D_push=16'h02AA, 16'h05BB, 16'hFFCC → RX holds 16'h02AA then 16'hFFCC; 16'h05BB ignored; rx_drop_cnt=0.
- RX full: fill with 8 matching packets, push a 9th with rx_rd=0 → dropped, rx_drop_cnt=1. Push a 10th with rx_rd=1 → captured, rx_full remains 1.
- Wrap-around: 20 write/pop pairs with values 0..19 → D_pop sequence exactly 0..19, no loss, tx_count ≤ 1.
- Async reset: assert reset low mid-cycle with 5 TX and 3 RX entries → pndng, rx_valid and tx_count drop to 0 immediately, without a clock edge. After release, a fresh write appears correctly.
